// File: rtl/seq_key_expansion.sv
// Iterative AES key schedule: one 32-bit schedule word per clock through a single
// shared SubWord path, filling the packed round-key bus for AES-128/192/256.
module seq_key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [Nk*32-1:0]         key,
  output logic [(Nr+1)*128-1:0]    allKeys,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int NW = 4 * (Nr + 1);
  localparam int KW = NW * 32;
  localparam int IW = $clog2(NW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  state_t          r_state;
  logic [KW-1:0]   r_all;
  logic [IW-1:0]   r_i;
  logic [2:0]      r_k;
  logic [7:0]      r_rcon;
  logic            r_busy;
  logic            r_done;

  logic [31:0]     w_words [NW];
  logic [31:0]     w_prev;
  logic [31:0]     w_old;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub;
  logic [31:0]     w_temp;
  logic [31:0]     w_new;
  logic [7:0]      w_rcon_next;
  logic            w_k_zero;

  // Word-granular view of the schedule so w[i-1] and w[i-Nk] are plain muxes.
  for (genvar g = 0; g < NW; g++) begin : g_words
    assign w_words[g] = r_all[KW-1-32*g -: 32];
  end

  always_comb begin
    w_prev      = w_words[r_i - IW'(1)];
    w_old       = w_words[r_i - IW'(Nk)];
    w_k_zero    = (r_k == 3'd0);
    // RotWord only feeds the shared S-box on the k==0 step.
    w_sub_in    = w_k_zero ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub       = sub_word(w_sub_in);
    w_temp      = w_prev;
    if (w_k_zero) begin
      w_temp = w_sub ^ {r_rcon, 24'h0};
    end else if (Nk == 8 && r_k == 3'd4) begin
      w_temp = w_sub;
    end
    w_new       = w_old ^ w_temp;
    w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_all   <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_rcon  <= 8'h01;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_all   <= {key, {(KW-Nk*32){1'b0}}};
            r_i     <= IW'(Nk);
            r_k     <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int j = Nk; j < NW; j++) begin
            if (r_i == IW'(j)) r_all[KW-1-32*j -: 32] <= w_new;
          end
          r_i <= r_i + IW'(1);
          r_k <= (r_k == 3'(Nk-1)) ? 3'd0 : r_k + 3'd1;
          if (w_k_zero) r_rcon <= w_rcon_next;
          if (r_i == IW'(NW-1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign allKeys   = r_all;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_key_expansion.sv
// Bench for seq_key_expansion: AES-128/192/256 instances checked against a FIPS-style
// key-schedule model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_seq_key_expansion;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
  logic [127:0]  key128 = '0;
  logic [191:0]  key192 = '0;
  logic [255:0]  key256 = '0;
  logic [1407:0] all128;
  logic [1663:0] all192;
  logic [1919:0] all256;
  logic          busy128, busy192, busy256;
  logic          done128, done192, done256;
  logic [1:0]    dbg128, dbg192, dbg256;

  seq_key_expansion #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .reset_n(reset_n), .start(start128), .key(key128),
    .allKeys(all128), .busy(busy128), .done(done128), .dbg_state(dbg128));
  seq_key_expansion #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .reset_n(reset_n), .start(start192), .key(key192),
    .allKeys(all192), .busy(busy192), .done(done192), .dbg_state(dbg192));
  seq_key_expansion #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .reset_n(reset_n), .start(start256), .key(key256),
    .allKeys(all256), .busy(busy256), .done(done256), .dbg_state(dbg256));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_m [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = {1'b0, b[7:1]};
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
    return b;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub(logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  // Schedule left-aligned in a 1920-bit vector; words past 4*(Nr+1) stay zero.
  function automatic logic [1919:0] ref_expand(int nk, logic [255:0] k);
    logic [31:0] w [60];
    logic [1919:0] r = '0;
    logic [7:0] rc = 8'h01;
    logic [31:0] t;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = m_sub(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic int lat_of(int nk);
    return 4 * (nk + 7) - nk;
  endfunction

  function automatic logic [127:0] last_rk(int nk, logic [1919:0] s);
    return s[1919-32*(4*(nk+7)-4) -: 128];
  endfunction

  // ---------------- DUT access ----------------
  task automatic set_start(int nk, logic v, logic [255:0] k);
    case (nk)
      4: begin start128 = v; key128 = k[255 -: 128]; end
      6: begin start192 = v; key192 = k[255 -: 192]; end
      default: begin start256 = v; key256 = k; end
    endcase
  endtask

  function automatic logic [1919:0] get_all(int nk);
    case (nk)
      4: return {all128, 512'b0};
      6: return {all192, 256'b0};
      default: return all256;
    endcase
  endfunction

  function automatic logic get_busy(int nk);
    return (nk == 4) ? busy128 : (nk == 6) ? busy192 : busy256;
  endfunction

  function automatic logic get_done(int nk);
    return (nk == 4) ? done128 : (nk == 6) ? done192 : done256;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sched(string name, logic [1919:0] act, logic [1919:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < 60; i++) begin
        if (act[1919-32*i -: 32] !== exp[1919-32*i -: 32]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, i,
                   act[1919-32*i -: 32], exp[1919-32*i -: 32]);
          break;
        end
      end
    end
  endtask

  // Drives start for one edge; returns #1 after the accepting edge.
  task automatic do_start(string tag, int nk, logic [255:0] k);
    @(negedge clk);
    set_start(nk, 1'b1, k);
    @(posedge clk);
    #1;
    set_start(nk, 1'b0, k);
    chk({tag, "_busy_on_accept"}, 128'(get_busy(nk)), 128'd1);
    chk({tag, "_done_on_accept"}, 128'(get_done(nk)), 128'd0);
  endtask

  // Counts edges until done; optional mid-run start pulse or reset abort.
  task automatic wait_done(string tag, int nk, int exp_n, int pulse_at,
                           logic [255:0] pk, int abort_at);
    int n = 0;
    bit fin = 0;
    bit busy_bad = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      n++;
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_sched({tag, "_abort_all"}, get_all(nk), '0);
        chk({tag, "_abort_busy"}, 128'(get_busy(nk)), 128'd0);
        chk({tag, "_abort_done"}, 128'(get_done(nk)), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (get_done(nk)) fin = 1;
      else if (!get_busy(nk)) busy_bad = 1;
      if (get_busy(nk) && get_done(nk)) busy_bad = 1;
      if (n >= 200) begin
        fin = 1;
        $display("FAIL %s_timeout: no done after %0d edges", tag, n);
      end
      if (n == pulse_at) set_start(nk, 1'b1, pk);
      else if (n == pulse_at + 1) set_start(nk, 1'b0, pk);
    end
    set_start(nk, 1'b0, pk);
    chk({tag, "_latency"}, 128'(n), 128'(exp_n));
    chk({tag, "_busy_profile"}, 128'(busy_bad), 128'd0);
    chk({tag, "_busy_at_done"}, 128'(get_busy(nk)), 128'd0);
  endtask

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] exp_last;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k, k2;
    logic [1919:0] s;
    build_sbox();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int nk = 4; nk <= 8; nk += 2) begin
      chk_sched($sformatf("reset_all_nk%0d", nk), get_all(nk), '0);
      chk($sformatf("reset_busy_nk%0d", nk), 128'(get_busy(nk)), 128'd0);
      chk($sformatf("reset_done_nk%0d", nk), 128'(get_done(nk)), 128'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // AES-128 known answer, with w[4] one edge after acceptance
    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_start("kat128", 4, k);
    @(posedge clk);
    #1;
    chk("kat128_w4", 128'(all128[1407-128 -: 32]), 128'h00000000000000000000000000d6aa74fd);
    wait_done("kat128", 4, lat_of(4) - 1, -10, k, -10);
    chk("kat128_last", all128[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("kat128_top", all128[1407 -: 128], 128'h000102030405060708090a0b0c0d0e0f);

    // Vector table: known answers then random keys checked against the model
    vecs[0] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'ha4970a331a78dc09c418c271e3a41d5d};
    vecs[2] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h24fc79ccbf0979e9371ac23c6d68de36};
    for (int v = 3; v < 9; v++) begin
      vecs[v].nk = 4 + 2 * (v % 3);
      vecs[v].key = '0;
      for (int w = 0; w < vecs[v].nk; w++) vecs[v].key[255-32*w -: 32] = $urandom();
      vecs[v].exp_last = last_rk(vecs[v].nk, ref_expand(vecs[v].nk, vecs[v].key));
    end
    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d_nk%0d", v, vecs[v].nk);
      do_start(tag, vecs[v].nk, vecs[v].key);
      wait_done(tag, vecs[v].nk, lat_of(vecs[v].nk), -10, vecs[v].key, -10);
      s = get_all(vecs[v].nk);
      chk({tag, "_last"}, last_rk(vecs[v].nk, s), vecs[v].exp_last);
      chk_sched({tag, "_sched"}, s, ref_expand(vecs[v].nk, vecs[v].key));
    end

    // Restart from DONE with an all-ones AES-128 key
    chk("restart_done_held", 128'(done128), 128'd1);
    k = {128'hffffffffffffffffffffffffffffffff, 128'h0};
    do_start("restart128", 4, k);
    wait_done("restart128", 4, lat_of(4), -10, k, -10);
    chk_sched("restart128_sched", get_all(4), ref_expand(4, k));

    // Start pulsed mid-run with a different key is ignored
    k  = '0;
    k2 = '0;
    for (int w = 0; w < 8; w++) begin
      k[255-32*w -: 32]  = $urandom();
      k2[255-32*w -: 32] = $urandom();
    end
    do_start("ignore256", 8, k);
    wait_done("ignore256", 8, lat_of(8), 10, k2, -10);
    chk_sched("ignore256_sched", get_all(8), ref_expand(8, k));

    // Reset mid-run aborts; a fresh start then runs to completion
    k = '0;
    for (int w = 0; w < 6; w++) k[255-32*w -: 32] = $urandom();
    do_start("abort192", 6, k);
    wait_done("abort192", 6, lat_of(6), -10, k, 20);
    do_start("after_abort192", 6, k);
    wait_done("after_abort192", 6, lat_of(6), -10, k, -10);
    chk_sched("after_abort192_sched", get_all(6), ref_expand(6, k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
